// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector.
// The detector shifts in bits while en is high and compares the last len bits
// against the active pattern. The pattern, length and overlap mode can be
// reloaded at run time, and match_count is a saturating count of matches.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    // Active configuration
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    // Detection state
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    // Registered outputs
    logic               y_q, y_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Intermediate values for the current edge
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               cfg_ok;
    logic               shift_en;
    logic               match;

    // Compare mask: only the low len bits of history and pattern take part
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    // History and fill as they would look after accepting x on this edge
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], x};
        fill_inc   = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
    end

    // Configuration validity and match decision; a config write takes the
    // edge, so the x sampled alongside it is dropped
    always_comb begin
        cfg_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
        shift_en = en && !cfg_we;
        match    = shift_en && (fill_inc >= len_q) &&
                   ((hist_shift & mask) == (pat_q & mask));
    end

    // Next-state for configuration, history, fill and outputs
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        err_d  = 1'b0;
        cnt_d  = cnt_q;

        if (cfg_we) begin
            if (cfg_ok) begin
                // New pattern starts from an empty history
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end else begin
                err_d  = 1'b1;
            end
        end else if (en) begin
            hist_d = hist_shift;
            // Non-overlap mode demands a complete fresh pattern after a hit
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
        end

        y_d = match;

        // Clear beats a simultaneous match; the counter never wraps
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous reset to the built-in 1011 detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q  <= RST_PATTERN;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= RST_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y           = y_q;
    assign cfg_err     = err_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed streams with hand-computed results plus
// a per-cycle comparison against a bit-list model of the detector. A second
// instance with a 2-bit counter exercises saturation.
module tb_seq_detect_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, x, cfg_we, cfg_overlap, cnt_clr;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        y0, y1, e0, e1;
    logic [15:0] c0;
    logic [1:0]  c1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detect_prog u_dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y0), .match_count(c0), .cfg_err(e0)
    );

    seq_detect_prog #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y1), .match_count(c1), .cfg_err(e1)
    );

    // Model: every accepted bit is kept in a list; a match is the last len
    // bits equalling the pattern, provided enough bits arrived since the last
    // restart point (reset, config load, or a non-overlapping match).
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_since;
    bit         m_bits[$];
    bit         m_y, m_err;
    int         m_cnt, m_cnt2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat   = 8'h0B;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_since = 0;
        m_bits.delete();
        m_y     = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_step();
        bit hit;
        hit   = 1'b0;
        m_err = 1'b0;
        if (cfg_we) begin
            if (cfg_len >= 2 && cfg_len <= 8) begin
                m_pat   = cfg_pattern;
                m_len   = int'(cfg_len);
                m_ovl   = cfg_overlap;
                m_since = 0;
                m_bits.delete();
            end else begin
                m_err = 1'b1;
            end
        end else if (en) begin
            m_bits.push_back(x);
            m_since++;
            if (m_since >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
            if (hit && !m_ovl) m_since = 0;
        end
        m_y = hit;
        if (cnt_clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("y", {31'd0, y0}, {31'd0, m_y});
        chk("y_cnt2", {31'd0, y1}, {31'd0, m_y});
        chk("match_count", {16'd0, c0}, m_cnt);
        chk("match_count_cnt2", {30'd0, c1}, m_cnt2);
        chk("cfg_err", {31'd0, e0}, {31'd0, m_err});
        chk("cfg_err_cnt2", {31'd0, e1}, {31'd0, m_err});
    end

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, return 1 time unit later with DUT outputs settled
    task automatic tick(input bit e, input bit b, input bit we = 1'b0, input bit clr = 1'b0);
        @(negedge clk);
        en      = e;
        x       = b;
        cfg_we  = we;
        cnt_clr = clr;
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                       input bit e = 1'b0, input bit b = 1'b0, input bit clr = 1'b0);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        tick(e, b, 1'b1, clr);
    endtask

    // Send n bits, first bit is bits[n-1]; ym[i] is y after bit i+1
    task automatic run(input int n, input logic [31:0] bits, output logic [31:0] ym);
        ym = '0;
        for (int i = 0; i < n; i++) begin
            tick(1'b1, bits[n - 1 - i]);
            ym[i] = y0;
        end
    endtask

    logic [31:0] ym;

    initial begin
        reset = 1'b1;
        en = 1'b0; x = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        model_reset();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("reset_y", {31'd0, y0}, 32'd0);
        chk("reset_cnt", {16'd0, c0}, 32'd0);
        chk("reset_err", {31'd0, e0}, 32'd0);
        reset = 1'b0;
        tick(1'b0, 1'b0);

        // Default overlapping 1011 detector
        run(7, 32'b1011011, ym);
        chk("default_ovl_y", ym, 32'h48);
        chk("default_ovl_cnt", {16'd0, c0}, 32'd2);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_clr", {16'd0, c0}, 32'd0);

        // Non-overlapping 1011
        cfg(8'h0B, 4'd4, 1'b0);
        run(7, 32'b1011011, ym);
        chk("nonovl_y", ym, 32'h08);
        chk("nonovl_cnt", {16'd0, c0}, 32'd1);

        // Eight-bit pattern A5, overlapping, counter cleared with the load
        cfg(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        run(13, 32'b1010010100101, ym);
        chk("len8_y", ym, 32'h1080);
        chk("len8_cnt", {16'd0, c0}, 32'd2);

        // Junk above len must be ignored; x during a config write is dropped
        cfg(8'hFB, 4'd4, 1'b1, 1'b1, 1'b1);
        run(3, 32'b011, ym);
        chk("cfg_drops_x", ym, 32'h0);
        cfg(8'h0B, 4'd4, 1'b1);

        // Rejected configurations keep 1011 overlapping
        cfg(8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("err_len0", {31'd0, e0}, 32'd1);
        tick(1'b0, 1'b0);
        chk("err_one_cycle", {31'd0, e0}, 32'd0);
        cfg(8'h00, 4'd9, 1'b0);
        chk("err_len9", {31'd0, e0}, 32'd1);
        run(4, 32'b1011, ym);
        chk("retained_cfg_y", ym, 32'h08);
        run(3, 32'b011, ym);
        chk("retained_ovl_y", ym, 32'h04);

        // Saturation of the 2-bit counter, then clear against a match
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(8'h0B, 4'd4, 1'b1);
        run(19, 32'b1011011011011011011, ym);
        chk("sat_y", ym, 32'h49248);
        chk("sat_cnt2", {30'd0, c1}, 32'd3);
        chk("sat_cnt16", {16'd0, c0}, 32'd6);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_vs_match_y", {31'd0, y0}, 32'd1);
        chk("clr_vs_match_cnt", {16'd0, c0}, 32'd0);
        chk("clr_vs_match_cnt2", {30'd0, c1}, 32'd0);

        // Reset mid-stream drops partial history
        run(3, 32'b101, ym);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset_y", {31'd0, y0}, 32'd0);
        tick(1'b0, 1'b0);
        reset = 1'b0;
        run(1, 32'b1, ym);
        chk("post_reset_no_y", ym, 32'h0);
        run(3, 32'b011, ym);
        chk("post_reset_y", ym, 32'h4);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
